// File: rtl/ion_sensor_responder_if.sv
// Signal bundle between the ion sensor responder, its request sources, the sensor and the result sink.
// master = responder side, slave = environment side.
interface ion_sensor_responder_if;
    logic [7:0]  i_s_request;
    logic [7:0]  stream_active;
    logic        sensor_ready;
    logic        sensor_valid;
    logic [15:0] sensor_data;
    logic        out_ready;
    logic        sensor_start;
    logic [2:0]  sensor_channel;
    logic        out_valid;
    logic [2:0]  out_stream;
    logic [15:0] out_data;
    logic [7:0]  pending;
    logic [7:0]  overrun;
    logic        timeout_err;

    // Handshakes: a transfer happens on a rising edge where valid (sensor_start / sensor_valid /
    // out_valid) and the matching ready are both 1; the source holds payload stable until then.
    modport master (
        input  i_s_request, stream_active, sensor_ready, sensor_valid, sensor_data, out_ready,
        output sensor_start, sensor_channel, out_valid, out_stream, out_data,
        output pending, overrun, timeout_err
    );

    modport slave (
        output i_s_request, stream_active, sensor_ready, sensor_valid, sensor_data, out_ready,
        input  sensor_start, sensor_channel, out_valid, out_stream, out_data,
        input  pending, overrun, timeout_err
    );
endinterface

// File: rtl/ion_sensor_responder.sv
// Collects per-stream sample requests, serves them round-robin through a single sensor
// command/response port and hands each captured sample downstream.
module ion_sensor_responder #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                           clock,
    input  logic                           resetn,
    ion_sensor_responder_if.master         bus,
    output logic [1:0]                     dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic [2:0]  channel_q, channel_d;
    logic [2:0]  out_stream_q, out_stream_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] out_data_q, out_data_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    logic [7:0]  grant_vec;
    logic [7:0]  req_eff;
    logic [2:0]  rr_idx;
    logic        rr_found;

    // Round-robin search starting one past the last granted stream.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!rr_found && pending_q[last_grant_q + 3'(k)]) begin
                rr_found = 1'b1;
                rr_idx   = last_grant_q + 3'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        channel_d    = channel_q;
        out_stream_d = out_stream_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        timeout_d    = 1'b0;
        grant_vec    = '0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_vec    = 8'b1 << rr_idx;
                    channel_d    = rr_idx;
                    last_grant_d = rr_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sensor_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A sample arriving on the last allowed cycle still counts.
                if (bus.sensor_valid) begin
                    out_data_d   = bus.sensor_data;
                    out_stream_d = channel_q;
                    state_d      = DELIVER;
                end else if (cnt_q == (TIMEOUT - 16'd1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DELIVER: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Deactivation beats a same-cycle request; a request beats a same-cycle grant.
    always_comb begin
        req_eff   = bus.i_s_request & bus.stream_active;
        pending_d = ((pending_q & ~grant_vec) | req_eff) & bus.stream_active;
        overrun_d = overrun_q | (req_eff & pending_q & ~grant_vec);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 3'd7;
            channel_q    <= '0;
            out_stream_q <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            channel_q    <= channel_d;
            out_stream_q <= out_stream_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.sensor_start   = (state_q == ISSUE);
    assign bus.sensor_channel = channel_q;
    assign bus.out_valid      = (state_q == DELIVER);
    assign bus.out_stream     = out_stream_q;
    assign bus.out_data       = out_data_q;
    assign bus.pending        = pending_q;
    assign bus.overrun        = overrun_q;
    assign bus.timeout_err    = timeout_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_ion_sensor_responder.sv
// Directed bench for ion_sensor_responder: round-robin service, overrun, timeout,
// backpressure on both handshakes and reset in mid-transaction.
module tb_ion_sensor_responder;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         failures = 0;
    logic [18:0] exp_q[$];

    ion_sensor_responder_if bus();

    ion_sensor_responder #(.TIMEOUT(16'd16)) dut (
        .clock       (clk),
        .resetn      (resetn),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] req);
        bus.i_s_request = req;
        tick();
        bus.i_s_request = 8'h00;
    endtask

    task automatic wait_start(input int ch);
        int n = 0;
        while (bus.sensor_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("start_seen", {31'd0, bus.sensor_start}, 32'd1);
        check("start_chan", {29'd0, bus.sensor_channel}, ch);
    endtask

    task automatic idle_watch(input int n, input string tag);
        int busy = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.sensor_start === 1'b1 || bus.out_valid === 1'b1) busy++;
        end
        check(tag, busy, 0);
    endtask

    // Serve one sensor transaction; hold > 0 stalls the result for that many cycles.
    task automatic serve(input int ch, input int delay, input logic [15:0] data, input int hold);
        logic [18:0] exp;
        logic [2:0]  ch3;
        ch3 = ch[2:0];
        wait_start(ch);
        bus.sensor_ready = 1'b1;
        tick();
        check("enter_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
        repeat (delay) tick();
        bus.sensor_valid = 1'b1;
        bus.sensor_data  = data;
        exp_q.push_back({ch3, data});
        tick();
        bus.sensor_valid = 1'b0;
        bus.sensor_data  = 16'h0000;
        exp = '1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("out_stream", {29'd0, bus.out_stream}, {29'd0, exp[18:16]});
        check("out_data", {16'd0, bus.out_data}, {16'd0, exp[15:0]});
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_stream", {29'd0, bus.out_stream}, {29'd0, exp[18:16]});
                check("hold_data", {16'd0, bus.out_data}, {16'd0, exp[15:0]});
            end
            bus.out_ready = 1'b1;
        end
        tick();
        check("post_xfer_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int tcount;
        bus.i_s_request   = 8'h00;
        bus.stream_active = 8'hFF;
        bus.sensor_ready  = 1'b1;
        bus.sensor_valid  = 1'b0;
        bus.sensor_data   = 16'h0000;
        bus.out_ready     = 1'b1;

        // reset state
        repeat (3) tick();
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("rst_start", {31'd0, bus.sensor_start}, 32'd0);
        check("rst_pending", {24'd0, bus.pending}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        resetn = 1'b1;
        tick();

        // all streams at once: latency, then strict 0..7 order
        pulse(8'hFF);
        check("lat_pending", {24'd0, bus.pending}, 32'hFF);
        check("lat_no_start_c1", {31'd0, bus.sensor_start}, 32'd0);
        tick();
        check("lat_start_c2", {31'd0, bus.sensor_start}, 32'd1);
        check("grant0_pending", {24'd0, bus.pending}, 32'hFE);
        for (int i = 0; i < 8; i++) serve(i, 3, 16'hA000 + 16'(i), 0);
        check("all_pending_clr", {24'd0, bus.pending}, 32'h00);
        check("all_overrun", {24'd0, bus.overrun}, 32'h00);

        // sensor_ready stall on stream 0 while stream 3 is requested twice
        bus.sensor_ready = 1'b0;
        pulse(8'h01);
        tick();
        wait_start(0);
        for (int i = 0; i < 5; i++) begin
            bus.i_s_request = (i == 1 || i == 3) ? 8'h08 : 8'h00;
            tick();
            check("stall_start", {31'd0, bus.sensor_start}, 32'd1);
            check("stall_chan", {29'd0, bus.sensor_channel}, 32'd0);
        end
        bus.i_s_request = 8'h00;
        check("ovr_pending", {24'd0, bus.pending}, 32'h08);
        check("ovr_flag", {24'd0, bus.overrun}, 32'h08);
        serve(0, 1, 16'h1234, 0);
        serve(3, 4, 16'hBEEF, 10);
        idle_watch(10, "single_result_s3");
        check("ovr_sticky", {24'd0, bus.overrun}, 32'h08);

        // timeout on stream 5
        pulse(8'h20);
        wait_start(5);
        tick();
        check("to_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
        tcount = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bus.timeout_err !== 1'b0 || dbg_state !== S_WAIT) tcount++;
        end
        check("to_early", tcount, 0);
        tick();
        check("to_pulse", {31'd0, bus.timeout_err}, 32'd1);
        check("to_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("to_no_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("to_pulse_end", {31'd0, bus.timeout_err}, 32'd0);
        bus.sensor_valid = 1'b1;
        bus.sensor_data  = 16'h5555;
        tick();
        bus.sensor_valid = 1'b0;
        check("stray_valid", {31'd0, bus.out_valid}, 32'd0);

        // reset in WAIT with more work pending
        pulse(8'h01);
        wait_start(0);
        tick();
        check("rw_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
        pulse(8'h30);
        check("rw_pending", {24'd0, bus.pending}, 32'h30);
        #3;
        resetn = 1'b0;
        #1;
        check("rw_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("rw_pending0", {24'd0, bus.pending}, 32'h00);
        check("rw_overrun0", {24'd0, bus.overrun}, 32'h00);
        check("rw_out_data0", {16'd0, bus.out_data}, 32'h0000);
        check("rw_out_stream0", {29'd0, bus.out_stream}, 32'd0);
        check("rw_chan0", {29'd0, bus.sensor_channel}, 32'd0);
        check("rw_outs0", {29'd0, bus.sensor_start, bus.out_valid, bus.timeout_err}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        bus.sensor_valid = 1'b1;
        idle_watch(20, "rw_no_result");
        bus.sensor_valid = 1'b0;

        // stream 0 first after reset; same-cycle request at grant; deactivation mid-transaction
        bus.sensor_ready = 1'b0;
        pulse(8'h81);
        check("f_pending", {24'd0, bus.pending}, 32'h81);
        pulse(8'h01);
        check("f_start", {31'd0, bus.sensor_start}, 32'd1);
        check("f_chan", {29'd0, bus.sensor_channel}, 32'd0);
        check("f_pending_keep", {24'd0, bus.pending}, 32'h81);
        check("f_no_overrun", {24'd0, bus.overrun}, 32'h00);
        bus.stream_active = 8'h7E;
        pulse(8'h80);
        check("f_deact_pending", {24'd0, bus.pending}, 32'h00);
        check("f_still_issue", {30'd0, dbg_state}, {30'd0, S_ISSUE});
        serve(0, 2, 16'h0F0F, 0);
        idle_watch(10, "f_quiet");
        bus.stream_active = 8'hFF;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
